// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encoding and
// the modulo step function used by every counter variant.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One modulo step in the requested direction; wraps at both ends.
    function automatic int unsigned mod_next(input int unsigned count,
                                             input logic        up,
                                             input int unsigned modulus);
        if (up == DIR_UP)
            return (count == modulus - 1) ? 0 : count + 1;
        else
            return (count == 0) ? modulus - 1 : count - 1;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with asynchronous active-high reset.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter whose state lives in a bank of T flip-flops;
// every update (step, load, clear) is expressed as a toggle vector.
module tff_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] t_vec;
    logic             wrap_next;
    logic             err_next;

    assign tc = en & (((up == DIR_UP) & (count == MAX_VAL)) |
                      ((up == DIR_DOWN) & (count == '0)));

    // Priority: clr > load > en > hold.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        err_next   = err;
        if (clr) begin
            count_next = '0;
            err_next   = 1'b0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                count_next = load_val;
            end else begin
                count_next = '0;
                err_next   = 1'b1;
            end
        end else if (en) begin
            count_next = WIDTH'(mod_next(32'(count), up, 32'(MODULUS)));
            wrap_next  = tc;
        end
    end

    assign t_vec = count ^ count_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[i]),
            .q   (count[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end else begin
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (rst)
                                     {1'b0, count} < MOD_W);

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter (WIDTH=4, MODULUS=10) including a
// two-digit cascade where the low digit's tc enables the high digit.
module tb_tff_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, up, clr, load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc, wrap, err;

    // cascade pair
    logic             c_clr;
    logic             c_en;
    logic [WIDTH-1:0] lo_count, hi_count;
    logic             lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [WIDTH:0] exp_q[$];  // {wrap, count}

    int up_seq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_seq[4]   = '{1, 0, 9, 8};

    tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .wrap(wrap), .err(err)
    );

    tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_lo (
        .clk(clk), .rst(rst), .en(c_en), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val('0), .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .err(lo_err)
    );

    tff_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_hi (
        .clk(clk), .rst(rst), .en(lo_tc), .up(1'b1), .clr(c_clr), .load(1'b0),
        .load_val('0), .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .err(hi_err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // driver tasks
    task automatic drive(input logic c, input logic l, input logic [WIDTH-1:0] lv,
                         input logic e, input logic u);
        clr = c; load = l; load_val = lv; en = e; up = u;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic check_scoreboard(input string tag);
        logic [WIDTH:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_count"}, 32'(count), 32'(e[WIDTH-1:0]));
            check_eq({tag, "_wrap"},  32'(wrap),  32'(e[WIDTH]));
        end
    endtask

    initial begin
        int lo_wraps;
        int hi_wraps;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        c_clr = 1'b0;
        c_en  = 1'b0;
        apply_reset();

        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_wrap",  32'(wrap),  0);
        check_eq("rst_err",   32'(err),   0);

        // bad load sets err; a valid load keeps it; async reset mid-count clears all
        drive(1'b0, 1'b1, 4'd12, 1'b0, 1'b1); step();
        check_eq("bad12_count", 32'(count), 0);
        check_eq("bad12_err",   32'(err),   1);
        drive(1'b0, 1'b1, 4'd7, 1'b0, 1'b1); step();
        check_eq("load7_count", 32'(count), 7);
        check_eq("load7_err",   32'(err),   1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_count", 32'(count), 0);
        check_eq("async_rst_err",   32'(err),   0);
        check_eq("async_rst_wrap",  32'(wrap),  0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step();
        check_eq("rst_held_count", 32'(count), 0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq($sformatf("post_rst_%0d", i), 32'(count), 32'(i));
        end

        // up wrap from 0 over 12 clocks
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1); step();
        check_eq("clr_count", 32'(count), 0);
        for (int i = 0; i < 12; i++)
            exp_q.push_back({(i == 9) ? 1'b1 : 1'b0, 4'(up_seq[i])});
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            #1;
            check_eq($sformatf("up_tc_%0d", i), 32'(tc), (i == 9) ? 1 : 0);
            step();
            check_scoreboard($sformatf("up_%0d", i));
        end

        // down wrap after loading 2
        drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b1); step();
        check_eq("load2_count", 32'(count), 2);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({(i == 2) ? 1'b1 : 1'b0, 4'(dn_seq[i])});
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("dn_tc_%0d", i), 32'(tc), (i == 2) ? 1 : 0);
            step();
            check_scoreboard($sformatf("dn_%0d", i));
        end

        // direction flip on the same edge: 8 -> 9, then en=0 gates tc at 9
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step();
        check_eq("flip_count", 32'(count), 9);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1); #1;
        check_eq("tc_en0", 32'(tc), 0);
        step();
        check_eq("hold_count", 32'(count), 9);

        // load while tc is high suppresses the wrap pulse
        drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b1); #1;
        check_eq("tc_at9", 32'(tc), 1);
        step();
        check_eq("load_over_tc_count", 32'(count), 3);
        check_eq("load_over_tc_wrap",  32'(wrap),  0);

        // priority
        drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1); step();
        check_eq("prio_clr", 32'(count), 0);
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1); step();
        check_eq("prio_load", 32'(count), 5);

        // bad load at the boundary, err sticky through steps, clr clears
        drive(1'b0, 1'b1, 4'd9, 1'b0, 1'b1); step();
        check_eq("load9_err", 32'(err), 0);
        drive(1'b0, 1'b1, 4'd10, 1'b0, 1'b1); step();
        check_eq("bad10_count", 32'(count), 0);
        check_eq("bad10_err",   32'(err),   1);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1); step(); step();
        check_eq("bad_steps_count", 32'(count), 2);
        check_eq("bad_steps_err",   32'(err),   1);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1); step();
        check_eq("clr_err",   32'(err),   0);
        check_eq("clr_count2", 32'(count), 0);

        // cascade: 100 clocks from 00 -> 00 with one high-digit wrap
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
        c_clr = 1'b1; step();
        c_clr = 1'b0;
        c_en  = 1'b1;
        lo_wraps = 0;
        hi_wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            lo_wraps += int'(lo_wrap);
            hi_wraps += int'(hi_wrap);
            if (i == 55) begin
                check_eq("casc55_lo", 32'(lo_count), 5);
                check_eq("casc55_hi", 32'(hi_count), 5);
            end
        end
        c_en = 1'b0;
        check_eq("casc_lo",       32'(lo_count), 0);
        check_eq("casc_hi",       32'(hi_count), 0);
        check_eq("casc_hi_wraps", 32'(hi_wraps), 1);
        check_eq("casc_lo_wraps", 32'(lo_wraps), 10);
        check_eq("casc_err",      32'(lo_err | hi_err), 0);
        check_eq("casc_hi_tc",    32'(hi_tc), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
